// File: rtl/rng_note_seq.sv
// LFSR random note sequencer: XNOR Fibonacci LFSR, tick divider and rejection-sampled note draws.
// Optional build macro RNG_NO_REPEAT_EN: reject a draw equal to the last accepted note.
module rng_note_seq #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hA455,
    parameter int               NOTE_W    = 6,
    parameter int               NUM_NOTES = 49,
    parameter int               DIV_W     = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed_in,
    input  logic [DIV_W-1:0]  rate,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    input  logic              note_ready,
    output logic              overrun,
    output logic [WIDTH-1:0]  lfsr_out
);

    typedef enum logic [1:0] {COUNT, DRAW, HOLD} state_t;

    localparam logic [WIDTH-1:0]  ONES        = '1;
    localparam logic [NOTE_W:0]   NUM_NOTES_V = (NOTE_W+1)'(NUM_NOTES);

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  lfsr, lfsr_nxt, lfsr_step;
    logic [DIV_W-1:0]  cnt, cnt_nxt;
    logic [NOTE_W-1:0] note_nxt, cand;
    logic              note_valid_nxt, overrun_nxt;
    logic              fb, tick, accept, cand_legal, cand_ok;

    // All-ones is the XNOR lock-up state, so it is steered back to SEED
    assign fb         = ~^(lfsr & TAPS);
    assign lfsr_step  = (lfsr == ONES) ? SEED : {lfsr[WIDTH-2:0], fb};
    assign tick       = en && (cnt == '0);
    assign accept     = note_valid && note_ready;
    assign cand       = lfsr[NOTE_W-1:0];
    assign cand_legal = {1'b0, cand} < NUM_NOTES_V;
    assign lfsr_out   = lfsr;

`ifdef RNG_NO_REPEAT_EN
    logic [NOTE_W-1:0] last_note;

    // A single legal note can never differ from itself, so the check is dropped then
    assign cand_ok = cand_legal && ((NUM_NOTES == 1) || (cand != last_note));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_note <= '0;
        end else if (accept) begin
            last_note <= note;
        end
    end
`else
    assign cand_ok = cand_legal;
`endif

    always_comb begin
        state_nxt      = state;
        lfsr_nxt       = lfsr;
        cnt_nxt        = cnt;
        note_nxt       = note;
        note_valid_nxt = note_valid;
        overrun_nxt    = overrun;
        if (seed_load) begin
            lfsr_nxt       = (seed_in == ONES) ? SEED : seed_in;
            cnt_nxt        = rate;
            state_nxt      = COUNT;
            overrun_nxt    = 1'b0;
            note_valid_nxt = 1'b0;
        end else begin
            if (en) begin
                lfsr_nxt = lfsr_step;
                cnt_nxt  = tick ? rate : cnt - DIV_W'(1);
            end
            unique case (state)
                COUNT: begin
                    if (tick) begin
                        state_nxt = DRAW;
                    end
                end
                DRAW: begin
                    // Candidate is taken from the pre-shift state; rejected ones retry next enabled cycle
                    if (en && cand_ok) begin
                        note_nxt       = cand;
                        note_valid_nxt = 1'b1;
                        state_nxt      = HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        note_valid_nxt = 1'b0;
                        state_nxt      = tick ? DRAW : COUNT;
                    end else if (tick) begin
                        overrun_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = COUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= COUNT;
            lfsr       <= SEED;
            cnt        <= '0;
            note       <= '0;
            note_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            lfsr       <= lfsr_nxt;
            cnt        <= cnt_nxt;
            note       <= note_nxt;
            note_valid <= note_valid_nxt;
            overrun    <= overrun_nxt;
        end
    end

endmodule
